// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state and mode encodings for the add/sub accumulator
package addsub_pkg;
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
endpackage

// File: rtl/addsub_core.sv
// addsub_core: ripple-carry adder/subtractor with carry-out and signed overflow
module addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] bx;
    assign bx   = b ^ {WIDTH{sub}};
    assign c[0] = sub;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    assign cout = c[WIDTH];
    // Inverted b makes the subtract rule (signs differ) the same test as the add rule.
    assign ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/addsub_accum.sv
// addsub_accum: two-strobe operand capture with registered add/sub/accumulate result
module addsub_accum
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             valid,
    output logic [1:0]       state
);
    state_t           st, nxt;
    logic             acc, do_sub, cout, ovf;
    logic [WIDTH-1:0] core_a, sum, sat_sum;
    assign acc    = (st == S_DONE) && (mode == MODE_ACC);
    assign do_sub = !acc && (mode == MODE_SUB);
    assign core_a = acc ? result : op_a;
    assign state  = st;
    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a    (core_a),
        .b    (din),
        .sub  (do_sub),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );
    // Saturation only replaces the stored result; flags keep the raw outcome.
    assign sat_sum = !SATURATE ? sum : do_sub ? (cout ? sum : '0) : (cout ? '1 : sum);
    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= S_A;
        else       st <= nxt;
    end
    // Next state: clear beats load; accumulate holds in S_DONE
    always_comb begin
        nxt = st;
        if (clear)     nxt = S_A;
        else if (load) nxt = (st == S_A) ? S_B : (st == S_B) ? S_DONE : acc ? S_DONE : S_B;
    end
    // Operand, result and flag registers update only on load
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else if (load) begin
            if (st == S_B || acc) begin
                op_a     <= acc ? result : op_a;
                op_b     <= din;
                result   <= sat_sum;
                carry    <= cout;
                overflow <= ovf;
                valid    <= 1'b1;
            end else begin
                op_a  <= din;
                valid <= 1'b0;
            end
        end
    end
endmodule
